// File: rtl/grid_tile_scanner.sv
// grid_tile_scanner: takes one grid cell request and streams every pixel
// coordinate inside that tile in raster order (x inner, y outer).
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   req_valid/req_ready     tile request handshake (ready only while idle)
//   req_x_grid, req_y_grid  requested grid column / row
//   pix_valid/pix_ready     pixel stream handshake with backpressure
//   pix_x, pix_y            pixel coordinate of the current beat
//   pix_first, pix_last     first / last beat of the tile
//   busy                    scan in progress
//   err_pulse               one-cycle pulse when an out-of-range cell is rejected
module grid_tile_scanner #(
  parameter int unsigned TILE      = 32,
  parameter int unsigned X_OFFSET  = 16,
  parameter int unsigned Y_OFFSET  = 16,
  parameter int unsigned GRID_COLS = 12,
  parameter int unsigned GRID_ROWS = 8
) (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_x_grid,
  input  logic [3:0] req_y_grid,
  output logic       pix_valid,
  input  logic       pix_ready,
  output logic [8:0] pix_x,
  output logic [8:0] pix_y,
  output logic       pix_first,
  output logic       pix_last,
  output logic       busy,
  output logic       err_pulse
);

  localparam int unsigned CW   = (TILE > 1) ? $clog2(TILE) : 1;
  localparam logic [CW-1:0] CMAX = CW'(TILE - 1);
  localparam logic [4:0] COLS  = 5'(GRID_COLS);
  localparam logic [4:0] ROWS  = 5'(GRID_ROWS);

  // Reject parameter sets whose tiles would leave the 9-bit pixel space.
  if ((X_OFFSET + GRID_COLS * TILE > 512) || (Y_OFFSET + GRID_ROWS * TILE > 512) ||
      (TILE < 2) || (GRID_COLS < 1) || (GRID_COLS > 16) ||
      (GRID_ROWS < 1) || (GRID_ROWS > 16)) begin : g_param_check
    $error("grid_tile_scanner: illegal parameter combination");
  end

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic [CW-1:0] cx;
  logic [CW-1:0] cy;
  logic [8:0]    x0;
  logic [8:0]    y0;

  // Next raster position and its derived flags.
  logic [CW-1:0] cx_nxt;
  logic [CW-1:0] cy_nxt;
  logic          last_nxt;
  logic          range_ok;
  logic [8:0]    base_x;
  logic [8:0]    base_y;

  always_comb begin
    cx_nxt = cx;
    cy_nxt = cy;
    if (cx == CMAX) begin
      cx_nxt = '0;
      cy_nxt = cy + CW'(1);
    end else begin
      cx_nxt = cx + CW'(1);
    end
    last_nxt = (cx_nxt == CMAX) && (cy_nxt == CMAX);
    range_ok = ({1'b0, req_x_grid} < COLS) && ({1'b0, req_y_grid} < ROWS);
    base_x   = 9'(X_OFFSET + 32'(req_x_grid) * TILE);
    base_y   = 9'(Y_OFFSET + 32'(req_y_grid) * TILE);
  end

  // Control FSM with all outputs registered.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      cx        <= '0;
      cy        <= '0;
      x0        <= '0;
      y0        <= '0;
      req_ready <= 1'b0;
      pix_valid <= 1'b0;
      pix_x     <= '0;
      pix_y     <= '0;
      pix_first <= 1'b0;
      pix_last  <= 1'b0;
      busy      <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          pix_valid <= 1'b0;
          pix_first <= 1'b0;
          pix_last  <= 1'b0;
          busy      <= 1'b0;
          if (req_valid && req_ready) begin
            if (!range_ok) begin
              err_pulse <= 1'b1;
            end else begin
              state     <= SCAN;
              req_ready <= 1'b0;
              busy      <= 1'b1;
              x0        <= base_x;
              y0        <= base_y;
              cx        <= '0;
              cy        <= '0;
              pix_valid <= 1'b1;
              pix_x     <= base_x;
              pix_y     <= base_y;
              pix_first <= 1'b1;
              pix_last  <= 1'b0;
            end
          end
        end
        SCAN: begin
          req_ready <= 1'b0;
          busy      <= 1'b1;
          // Beat only moves on acceptance; otherwise everything holds.
          if (pix_valid && pix_ready) begin
            if (pix_last) begin
              state     <= IDLE;
              pix_valid <= 1'b0;
              pix_first <= 1'b0;
              pix_last  <= 1'b0;
              busy      <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              cx        <= cx_nxt;
              cy        <= cy_nxt;
              pix_x     <= x0 + 9'(cx_nxt);
              pix_y     <= y0 + 9'(cy_nxt);
              pix_first <= 1'b0;
              pix_last  <= last_nxt;
            end
          end
        end
        default: begin
          state     <= IDLE;
          pix_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grid_tile_scanner.sv
module tb_grid_tile_scanner;

  logic       clk_in = 1'b0;
  logic       rst_n_in;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_x_grid;
  logic [3:0] req_y_grid;
  logic       pix_valid;
  logic       pix_ready;
  logic [8:0] pix_x;
  logic [8:0] pix_y;
  logic       pix_first;
  logic       pix_last;
  logic       busy;
  logic       err_pulse;

  int tests = 0;
  int fails = 0;

  grid_tile_scanner dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x_grid (req_x_grid),
    .req_y_grid (req_y_grid),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_x      (pix_x),
    .pix_y      (pix_y),
    .pix_first  (pix_first),
    .pix_last   (pix_last),
    .busy       (busy),
    .err_pulse  (err_pulse)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Request one tile and follow its stream at negedges. Expected coordinates
  // come from x0/y0 plus the raster index; b33/last values are hand-computed.
  task automatic run_tile(input int gx, input int gy, input int x0, input int y0,
                          input int b33x, input int b33y, input int lx, input int ly,
                          input bit rnd, input int abort_at);
    int beat;
    int cyc;
    bit aborted;
    beat = 0;
    cyc = 0;
    aborted = 0;
    req_valid  = 1'b1;
    req_x_grid = 4'(gx);
    req_y_grid = 4'(gy);
    @(negedge clk_in);
    req_valid = 1'b0;
    check("first_beat", {pix_valid, pix_x, pix_y, pix_first},
          {1'b1, 9'(x0), 9'(y0), 1'b1});
    while (beat < 1024 && cyc < 8000) begin
      if (beat == abort_at) begin
        aborted = 1;
        break;
      end
      pix_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      check("beat", {pix_valid, pix_x, pix_y, pix_first, pix_last, busy, req_ready},
            {1'b1, 9'(x0 + beat % 32), 9'(y0 + beat / 32), beat == 0, beat == 1023,
             1'b1, 1'b0});
      if (beat == 32) check("beat33", {pix_x, pix_y}, {9'(b33x), 9'(b33y)});
      if (beat == 1023) check("last_coord", {pix_x, pix_y, pix_last}, {9'(lx), 9'(ly), 1'b1});
      if (rnd) check("map_back", {(32'(pix_x) - 16) / 32, (32'(pix_y) - 16) / 32},
                     {32'(gx), 32'(gy)});
      if (pix_ready) beat++;
      @(negedge clk_in);
      cyc++;
    end
    pix_ready = 1'b0;
    if (!aborted) begin
      check("beat_count", 64'(beat), 64'd1024);
      check("done_idle", {pix_valid, busy, req_ready}, {1'b0, 1'b0, 1'b1});
    end
  endtask

  initial begin
    rst_n_in   = 1'b0;
    req_valid  = 1'b0;
    req_x_grid = '0;
    req_y_grid = '0;
    pix_ready  = 1'b0;

    // 1: reset held 5 cycles
    repeat (5) @(negedge clk_in);
    check("reset_outs", {req_ready, pix_valid, busy, err_pulse, pix_first, pix_last, pix_x, pix_y},
          64'd0);
    rst_n_in = 1'b1;
    #1 check("ready_before_edge", 64'(req_ready), 64'd0);
    @(negedge clk_in);
    check("ready_after_edge", {req_ready, pix_valid, busy}, {1'b1, 1'b0, 1'b0});

    // 2: tile (0,0), always ready
    run_tile(0, 0, 16, 16, 16, 17, 47, 47, 1'b0, -1);

    // 3: tile (11,7), always ready
    run_tile(11, 7, 368, 240, 368, 241, 399, 271, 1'b0, -1);

    // 4: out-of-range requests
    req_valid = 1'b1; req_x_grid = 4'd12; req_y_grid = 4'd0;
    @(negedge clk_in);
    req_valid = 1'b0;
    check("err_col", {err_pulse, pix_valid, req_ready, busy}, {1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk_in);
    check("err_col_clear", {err_pulse, pix_valid, req_ready}, {1'b0, 1'b0, 1'b1});
    req_valid = 1'b1; req_x_grid = 4'd0; req_y_grid = 4'd8;
    @(negedge clk_in);
    req_valid = 1'b0;
    check("err_row", {err_pulse, pix_valid, req_ready, busy}, {1'b1, 1'b0, 1'b1, 1'b0});
    @(negedge clk_in);
    check("err_row_clear", {err_pulse, pix_valid, req_ready}, {1'b0, 1'b0, 1'b1});

    // 5: tile (3,2) with random backpressure
    run_tile(3, 2, 112, 80, 112, 81, 143, 111, 1'b1, -1);

    // 6: reset in the middle of tile (5,5)
    run_tile(5, 5, 176, 176, 176, 177, 207, 207, 1'b0, 100);
    rst_n_in = 1'b0;
    #1 check("async_reset", {pix_valid, busy}, {1'b0, 1'b0});
    repeat (2) @(negedge clk_in);
    rst_n_in = 1'b1;
    @(negedge clk_in);
    check("ready_after_abort", {req_ready, pix_valid}, {1'b1, 1'b0});
    run_tile(1, 1, 48, 48, 48, 49, 79, 79, 1'b0, -1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
